// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared constants for the sequential multiply/divide controller.
// Revision : 1.0
// ============================================================================
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Start/done request bus of the sequential multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub
// Brief    : Combinational WIDTH-bit adder/subtractor; co is carry (add) or
//            borrow, i.e. x < y (subtract).
// Revision : 1.0
// ============================================================================
module seq_addsub #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] x,
  input  wire logic [WIDTH-1:0] y,
  input  wire logic             sub,
  output logic      [WIDTH-1:0] s,
  output logic                  co
);
  logic [WIDTH:0] w_sum;

  always_comb begin
    if (sub) w_sum = {1'b0, x} - {1'b0, y};
    else     w_sum = {1'b0, x} + {1'b0, y};
  end

  assign s  = w_sum[WIDTH-1:0];
  assign co = w_sum[WIDTH];
endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Unsigned shift-add multiply / restoring divide sequencer sharing
//            one add/sub unit. Divide path enabled by macro ALU_SEQ_DIV_EN.
// Revision : 1.0
// ============================================================================
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic clk,
  input  wire logic reset,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // hi (multiply) / R (divide)
  logic [WIDTH-1:0]   lo_q, lo_d;       // lo (multiply) / Q (divide)
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // A (multiply) / B (divide)
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   add_x, add_s, hi_new, it_acc, it_lo;
  logic               add_co, add_sub, mul_carry;

`ifdef ALU_SEQ_DIV_EN
  logic               op_q, op_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   sh_r, sh_q;

  assign sh_r    = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign sh_q    = {lo_q[WIDTH-2:0], 1'b0};
  assign add_sub = (op_q == OP_DIV);
  assign add_x   = add_sub ? sh_r : acc_q;
`else
  logic unused_op;
  assign unused_op = bus.op;
  assign add_sub   = 1'b0;
  assign add_x     = acc_q;
`endif

  seq_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (add_x),
    .y   (opnd_q),
    .sub (add_sub),
    .s   (add_s),
    .co  (add_co)
  );

  // One iteration of whichever algorithm is in flight.
  always_comb begin
    hi_new    = lo_q[0] ? add_s : acc_q;
    mul_carry = lo_q[0] & add_co;
    it_acc    = {mul_carry, hi_new[WIDTH-1:1]};
    it_lo     = {hi_new[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    if (add_sub) begin
      it_acc = add_co ? sh_r : add_s;
      it_lo  = {sh_q[WIDTH-1:1], ~add_co};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= OP_MUL;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= op_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
`ifdef ALU_SEQ_DIV_EN
    op_d     = op_q;
    dbz_d    = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          cnt_d    = CW'(WIDTH);
          acc_d    = '0;
          lo_d     = bus.B;
          opnd_d   = bus.A;
          result_d = '0;
`ifdef ALU_SEQ_DIV_EN
          op_d     = bus.op;
          dbz_d    = 1'b0;
          if (bus.op == OP_DIV) begin
            lo_d   = bus.A;
            opnd_d = bus.B;
            if (bus.B == '0) begin
              state_d  = ST_DONE;
              cnt_d    = '0;
              result_d = {bus.A, {WIDTH{1'b1}}};
              dbz_d    = 1'b1;
            end
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = it_acc;
        lo_d  = it_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = {it_acc, it_lo};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q != ST_IDLE);
    bus.done   = (state_q == ST_DONE);
    bus.result = result_q;
`ifdef ALU_SEQ_DIV_EN
    bus.div_by_zero = dbz_q;
`else
    bus.div_by_zero = 1'b0;
`endif
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Directed vector bench for alu_seq_ctrl (WIDTH = 4).
// Revision : 1.0
// ============================================================================
module tb_alu_seq_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;

  alu_seq_if #(.WIDTH(4)) bus ();

  alu_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at cycle 0 and follow it to completion.
  task automatic do_op(input vec_t v, input string tag);
    int   cyc;
    logic got;
    logic all_busy;
    logic [7:0] res_at_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.A     = v.a;
    bus.B     = v.b;
    step();
    bus.start = 1'b0;
    bus.A     = 4'($urandom);
    bus.B     = 4'($urandom);
    if (v.lat > 1) begin
      check({tag, " cleared result"}, 32'(bus.result), 32'h0);
      check({tag, " cleared dbz"}, 32'(bus.div_by_zero), 32'h0);
    end
    cyc = 1;
    got = 1'b0;
    all_busy = 1'b1;
    while (!got && cyc <= 20) begin
      all_busy = all_busy & bus.busy;
      if (bus.done) got = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    check({tag, " done seen"}, 32'(got), 32'h1);
    check({tag, " done cycle"}, 32'(cyc), 32'(v.lat));
    check({tag, " busy span"}, 32'(all_busy), 32'h1);
    check({tag, " result"}, 32'(bus.result), 32'(v.res));
    check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(v.dbz));
    res_at_done = bus.result;
    step();
    check({tag, " done pulse"}, 32'({bus.done, bus.busy}), 32'h0);
    check({tag, " result hold"}, 32'(bus.result), 32'(res_at_done));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] done_seen;
    logic [12:0] busy_seen;
    logic        extra;
    n_vec  = 0;
    n_fail = 0;

    vecs[0] = '{1'b0, 4'd13, 4'd11, 8'd143, 1'b0, 5};
    vecs[1] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0, 5};
    vecs[2] = '{1'b0, 4'd0,  4'd9,  8'h00, 1'b0, 5};
    vecs[3] = '{1'b0, 4'd7,  4'd1,  8'h07, 1'b0, 5};
`ifdef ALU_SEQ_DIV_EN
    vecs[4] = '{1'b1, 4'd13, 4'd4,  8'h13, 1'b0, 5};
    vecs[5] = '{1'b1, 4'd14, 4'd13, 8'h11, 1'b0, 5};
    vecs[6] = '{1'b1, 4'd5,  4'd7,  8'h50, 1'b0, 5};
    vecs[7] = '{1'b1, 4'd9,  4'd0,  8'h9F, 1'b1, 1};
    vecs[8] = '{1'b1, 4'd15, 4'd15, 8'h01, 1'b0, 5};
    vecs[9] = '{1'b1, 4'd6,  4'd2,  8'h03, 1'b0, 5};
`else
    // op is ignored: every request multiplies.
    vecs[4] = '{1'b1, 4'd13, 4'd4,  8'h34, 1'b0, 5};
    vecs[5] = '{1'b1, 4'd14, 4'd13, 8'hB6, 1'b0, 5};
    vecs[6] = '{1'b1, 4'd5,  4'd7,  8'h23, 1'b0, 5};
    vecs[7] = '{1'b1, 4'd9,  4'd0,  8'h00, 1'b0, 5};
    vecs[8] = '{1'b1, 4'd15, 4'd15, 8'hE1, 1'b0, 5};
    vecs[9] = '{1'b1, 4'd6,  4'd2,  8'h0C, 1'b0, 5};
`endif

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset outputs", 32'({bus.busy, bus.done, bus.div_by_zero, bus.result}), 32'h0);
    step();

    for (int i = 0; i < 10; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // start held high through cycles 0-8: accepts at cycle 0 and cycle 6 only
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.A     = 4'd3;
    bus.B     = 4'd5;
    done_seen = '0;
    busy_seen = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 9) bus.start = 1'b0;
      done_seen[c] = bus.done;
      busy_seen[c] = bus.busy;
    end
    check("hold done cycles", 32'(done_seen), 32'h0820);
    check("hold busy cycles", 32'(busy_seen), 32'h0FBE);
    check("hold result", 32'(bus.result), 32'h0F);

    // A start pulse in mid-run must neither disturb nor queue.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 4'd3;
    bus.B     = 4'd5;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    bus.A     = 4'd1;
    bus.B     = 4'd1;
    step();
    bus.start = 1'b0;
    repeat (2) step();
    check("ignored start done", 32'(bus.done), 32'h1);
    check("ignored start result", 32'(bus.result), 32'h0F);
    extra = 1'b0;
    repeat (8) begin
      step();
      extra = extra | bus.busy | bus.done;
    end
    check("ignored start no queue", 32'(extra), 32'h0);

    // Reset asserted in cycle 3 of a multiply abandons it.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.A     = 4'd13;
    bus.B     = 4'd11;
    step();
    bus.start = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid reset outputs", 32'({bus.busy, bus.done, bus.div_by_zero, bus.result}), 32'h0);
    extra = 1'b0;
    repeat (6) begin
      step();
      extra = extra | bus.busy | bus.done;
    end
    check("mid reset no done", 32'(extra), 32'h0);
    do_op('{1'b0, 4'd2, 4'd3, 8'h06, 1'b0, 5}, "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
